// File: rtl/pe_split_if.sv
// Valid/ready token channel shared by the split's input and output ports.
// master drives data/valid and samples ready; slave does the reverse.
interface pe_split_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] data;
    logic             valid;
    logic             ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/pe_split.sv
// Two-way demultiplexer: joins a data token (l) with a select token (s) and queues the
// data into a small per-output FIFO (r0 for select 0, r1 for select 1).
module pe_split #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    pe_split_if.slave   l,
    pe_split_if.slave   s,
    pe_split_if.master  r0,
    pe_split_if.master  r1
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem    [2][DEPTH];
    logic [PW-1:0]    r_rd_ptr [2];
    logic [PW-1:0]    r_wr_ptr [2];
    logic [CW-1:0]    r_count  [2];

    logic       w_sel;
    logic       w_fire;
    logic [1:0] w_space;
    logic [1:0] w_push;
    logic [1:0] w_pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Space comes from registered counts only, so a consumer's ready never reaches l/s ready.
    always_comb begin
        w_space = '0;
        for (int i = 0; i < 2; i++) begin
            w_space[i] = !rst && (r_count[i] < CW'(DEPTH));
        end
    end

    assign w_sel   = s.data[0];
    assign l.ready = s.valid & w_space[w_sel];
    assign s.ready = l.valid & w_space[w_sel];
    assign w_fire  = l.valid & s.valid & w_space[w_sel];

    assign w_push[0] = w_fire & ~w_sel;
    assign w_push[1] = w_fire &  w_sel;
    assign w_pop[0]  = r0.valid & r0.ready;
    assign w_pop[1]  = r1.valid & r1.ready;

    assign r0.valid = (r_count[0] != '0);
    assign r1.valid = (r_count[1] != '0);
    assign r0.data  = r0.valid ? r_mem[0][r_rd_ptr[0]] : '0;
    assign r1.data  = r1.valid ? r_mem[1][r_rd_ptr[1]] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                r_rd_ptr[i] <= '0;
                r_wr_ptr[i] <= '0;
                r_count[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (w_push[i]) r_wr_ptr[i] <= next_ptr(r_wr_ptr[i]);
                if (w_pop[i])  r_rd_ptr[i] <= next_ptr(r_rd_ptr[i]);
                case ({w_push[i], w_pop[i]})
                    2'b10:   r_count[i] <= r_count[i] + 1'b1;
                    2'b01:   r_count[i] <= r_count[i] - 1'b1;
                    default: r_count[i] <= r_count[i];
                endcase
            end
        end
    end

    // NOTE: storage is deliberately not reset; empty FIFOs force their data outputs to 0.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (w_push[i]) r_mem[i][r_wr_ptr[i]] <= l.data;
        end
    end
endmodule

// File: tb/tb_pe_split.sv
// Directed and random bench for pe_split: a negedge monitor keeps one expected-data
// queue per output, filled on input handshakes and drained on output handshakes.
module tb_pe_split;
    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [7:0] q0[$];
    logic [7:0] q1[$];

    pe_split_if #(.WIDTH(8)) l_if ();
    pe_split_if #(.WIDTH(1)) s_if ();
    pe_split_if #(.WIDTH(8)) r0_if ();
    pe_split_if #(.WIDTH(8)) r1_if ();

    pe_split #(.WIDTH(8), .DEPTH(2)) dut (
        .clk (clk),
        .rst (rst),
        .l   (l_if.slave),
        .s   (s_if.slave),
        .r0  (r0_if.master),
        .r1  (r1_if.master)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic drive(input logic lv, input logic [7:0] ld, input logic sv, input logic sd);
        l_if.valid = lv;
        l_if.data  = ld;
        s_if.valid = sv;
        s_if.data  = sd;
    endtask

    // Scoreboard: reset discards everything in flight.
    always @(negedge clk) begin
        logic [31:0] exp;
        if (rst) begin
            q0.delete();
            q1.delete();
        end else begin
            if (r0_if.valid && r0_if.ready) begin
                exp = (q0.size() != 0) ? {24'h0, q0.pop_front()} : 32'hDEAD_BEEF;
                check("r0_data", {24'h0, r0_if.data}, exp);
            end
            if (r1_if.valid && r1_if.ready) begin
                exp = (q1.size() != 0) ? {24'h0, q1.pop_front()} : 32'hDEAD_BEEF;
                check("r1_data", {24'h0, r1_if.data}, exp);
            end
            if (l_if.valid && s_if.valid && l_if.ready && s_if.ready) begin
                if (s_if.data == 1'b0) q0.push_back(l_if.data);
                else                   q1.push_back(l_if.data);
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] t3[3];
        logic [7:0] cur_d;
        logic       cur_s;
        bit         pending;
        bit         did_rst;
        int         sent;
        int         cyc;

        t3 = '{8'h3C, 8'h7E, 8'h01};
        r0_if.ready = 1'b0;
        r1_if.ready = 1'b0;
        drive(1'b1, 8'hFF, 1'b1, 1'b0);

        // 1) reset held two cycles with inputs active
        step();
        step();
        sample();
        check("rst_r0_valid", r0_if.valid, 1'b0);
        check("rst_r1_valid", r1_if.valid, 1'b0);
        check("rst_r0_data",  r0_if.data, 8'h00);
        check("rst_r1_data",  r1_if.data, 8'h00);
        check("rst_l_ready",  l_if.ready, 1'b0);
        check("rst_s_ready",  s_if.ready, 1'b0);

        // 2) single token to R0, latency 1
        step();
        rst = 1'b0;
        drive(1'b1, 8'hA5, 1'b1, 1'b0);
        sample();
        check("s2_l_ready", l_if.ready, 1'b1);
        check("s2_s_ready", s_if.ready, 1'b1);
        step();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        sample();
        check("s2_r0_valid", r0_if.valid, 1'b1);
        check("s2_r0_data",  r0_if.data, 8'hA5);
        check("s2_r1_valid", r1_if.valid, 1'b0);
        step();
        r0_if.ready = 1'b1;
        sample();
        step();
        sample();
        check("s2_r0_empty", r0_if.valid, 1'b0);
        check("s2_r0_zero",  r0_if.data, 8'h00);

        // 3) back-to-back stream to R1
        r1_if.ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            if (k < 3) drive(1'b1, t3[k], 1'b1, 1'b1);
            else       drive(1'b0, 8'h00, 1'b0, 1'b0);
            sample();
            if (k > 0) begin
                check("s3_r1_valid", r1_if.valid, 1'b1);
                check("s3_r1_data",  r1_if.data, t3[k-1]);
            end
        end
        step();
        sample();
        check("s3_r1_drained", r1_if.valid, 1'b0);

        // 4) R0 stalled and full; R1 traffic still flows
        r0_if.ready = 1'b0;
        step();
        drive(1'b1, 8'h11, 1'b1, 1'b0);
        sample();
        step();
        drive(1'b1, 8'h22, 1'b1, 1'b0);
        sample();
        step();
        drive(1'b1, 8'h44, 1'b1, 1'b0);
        sample();
        check("s4_full_l_ready", l_if.ready, 1'b0);
        check("s4_full_s_ready", s_if.ready, 1'b0);
        check("s4_r0_hold",      r0_if.data, 8'h11);
        step();
        sample();
        check("s4_still_stalled", l_if.ready, 1'b0);
        check("s4_r0_hold2",      r0_if.data, 8'h11);
        step();
        drive(1'b1, 8'h33, 1'b1, 1'b1);
        sample();
        check("s4_r1_passes", l_if.ready, 1'b1);
        step();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        sample();
        check("s4_r1_valid", r1_if.valid, 1'b1);
        check("s4_r1_data",  r1_if.data, 8'h33);
        // A pop from the full FIFO frees space only from the following cycle.
        step();
        r0_if.ready = 1'b1;
        drive(1'b1, 8'h55, 1'b1, 1'b0);
        sample();
        check("s4_pop_not_yet", l_if.ready, 1'b0);
        step();
        sample();
        check("s4_pop_visible", l_if.ready, 1'b1);
        step();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        sample();

        // 5) data without select: nothing consumed
        repeat (4) begin
            step();
            sample();
        end
        for (int k = 0; k < 5; k++) begin
            step();
            drive(1'b1, 8'hAA, 1'b0, 1'b0);
            sample();
            check("s5_r0_valid", r0_if.valid, 1'b0);
            check("s5_r1_valid", r1_if.valid, 1'b0);
        end
        step();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        sample();
        check("s5_q0_empty", q0.size(), 0);
        check("s5_q1_empty", q1.size(), 0);

        // 6) random traffic with a reset pulse mid-run
        pending = 1'b0;
        did_rst = 1'b0;
        sent    = 0;
        cyc     = 0;
        cur_d   = 8'h00;
        cur_s   = 1'b0;
        while (sent < 1000 && cyc < 20000) begin
            step();
            cyc++;
            if (!did_rst && sent >= 500) begin
                rst = 1'b1;
                drive(1'b0, 8'h00, 1'b0, 1'b0);
                pending = 1'b0;
                did_rst = 1'b1;
                sample();
                step();
                rst = 1'b0;
                sample();
                check("s6_post_rst_r0", r0_if.valid, 1'b0);
                check("s6_post_rst_r1", r1_if.valid, 1'b0);
            end else begin
                r0_if.ready = ($urandom_range(0, 3) != 0);
                r1_if.ready = ($urandom_range(0, 3) != 0);
                if (!pending && $urandom_range(0, 4) != 0) begin
                    cur_d   = 8'($urandom);
                    cur_s   = 1'($urandom);
                    pending = 1'b1;
                end
                if (pending) drive(1'b1, cur_d, 1'b1, cur_s);
                else         drive(1'b0, 8'h00, 1'b0, 1'b0);
                sample();
                if (pending && l_if.ready && s_if.ready) begin
                    pending = 1'b0;
                    sent++;
                end
            end
        end
        check("s6_tokens_sent", sent, 1000);

        step();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        r0_if.ready = 1'b1;
        r1_if.ready = 1'b1;
        repeat (8) begin
            step();
            sample();
        end
        check("s6_q0_drained", q0.size(), 0);
        check("s6_q1_drained", q1.size(), 0);
        check("s6_r0_idle",    r0_if.valid, 1'b0);
        check("s6_r1_idle",    r1_if.valid, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
